// File: rtl/aes_engine_arbiter.sv
// Two-channel round-robin front end for a byte-serial aes_engine core:
// serialises key/plaintext into the engine and reassembles the 16 ciphertext bytes.
module aes_engine_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_key,
  input  logic [127:0] req0_plain,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_key,
  input  logic [127:0] req1_plain,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [127:0] rsp_cipher,
  output logic [7:0]   eng_din,
  output logic [1:0]   eng_cmd,
  input  logic         eng_ready,
  input  logic [7:0]   eng_dout,
  input  logic         eng_data_ok,
  output logic         grant_id,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_KEY, S_SEND_PT, S_WAIT_OUT, S_COLLECT, S_RESP
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e         state_q, state_d;
  logic [127:0]   key_q, key_d, pt_q, pt_d, cipher_q, cipher_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [15:0]    tmo_q, tmo_d;
  logic           grant_q, grant_d, last_q, last_d;
  logic           win1;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      pt_q     <= '0;
      cipher_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      pt_q     <= pt_d;
      cipher_q <= cipher_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    pt_d        = pt_q;
    cipher_d    = cipher_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    grant_d     = grant_q;
    last_d      = last_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    eng_cmd     = 2'b00;
    eng_din     = '0;
    timeout_err = 1'b0;
    // On a tie the channel not served last wins.
    win1 = req1_valid && (!req0_valid || !last_q);

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = !win1;
          req1_ready = win1;
          key_d      = win1 ? req1_key   : req0_key;
          pt_d       = win1 ? req1_plain : req0_plain;
          grant_d    = win1;
          last_d     = win1;
          cnt_d      = '0;
          state_d    = S_SEND_KEY;
        end
      end
      S_SEND_KEY, S_SEND_PT: begin
        // ~cnt selects byte 15-cnt, i.e. most-significant byte first.
        if (state_q == S_SEND_KEY) begin
          eng_cmd = 2'b01;
          eng_din = key_q[{~cnt_q, 3'b000} +: 8];
        end else begin
          eng_cmd = 2'b10;
          eng_din = pt_q[{~cnt_q, 3'b000} +: 8];
        end
        if (eng_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = (state_q == S_SEND_KEY) ? S_SEND_PT : S_WAIT_OUT;
            tmo_d   = '0;
          end
        end
      end
      S_WAIT_OUT, S_COLLECT: begin
        if (eng_data_ok) begin
          cipher_d = {cipher_q[119:0], eng_dout};
          tmo_d    = '0;
          cnt_d    = cnt_q + 4'd1;
          if (state_q == S_WAIT_OUT)
            state_d = S_COLLECT;
          else if (cnt_q == 4'd15)
            state_d = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          timeout_err = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_RESP: begin
        rsp0_valid = !grant_q;
        rsp1_valid = grant_q;
        if (grant_q ? rsp1_ready : rsp0_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_cipher = cipher_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_engine_arbiter.sv
// Scoreboard bench for aes_engine_arbiter with a behavioural byte-serial engine
// model that answers two known AES-128 vectors.
module tb_aes_engine_arbiter;

  localparam logic [127:0] V1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V2P = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V2C = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0, rst_ = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [127:0] req0_key = '0, req0_plain = '0, req1_key = '0, req1_plain = '0;
  logic rsp0_valid, rsp1_valid, rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [127:0] rsp_cipher;
  logic [7:0] eng_din, eng_dout = '0;
  logic [1:0] eng_cmd;
  logic eng_ready = 1'b1, eng_data_ok = 1'b0;
  logic grant_id, busy, timeout_err;

  aes_engine_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_(rst_),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_plain(req0_plain),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_plain(req1_plain),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_cipher(rsp_cipher), .eng_din(eng_din), .eng_cmd(eng_cmd), .eng_ready(eng_ready),
    .eng_dout(eng_dout), .eng_data_ok(eng_data_ok), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] key; logic [127:0] pt; } in_t;
  typedef struct { logic ch; logic [127:0] ct; } rsp_t;
  in_t  exp_in_q[$];
  rsp_t exp_rsp_q[$];
  logic exp_grant_q[$];

  int tests = 0, fails = 0, cyc = 0;
  logic [127:0] exp_ct0, exp_ct1;
  bit want0, want1;
  bit toggle_mode = 0, gap_mode = 0, stall5 = 0;
  int rsp_hold = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] aes_lut(input logic [127:0] k, input logic [127:0] p);
    if (k == V1K && p == V1P) return V1C;
    if (k == V2K && p == V2P) return V2C;
    return '0;
  endfunction

  always @(posedge clk) cyc++;

  // Engine model: sample accepted input bytes mid-cycle, drive outputs after the edge.
  logic [127:0] rx_key, rx_pt;
  int kb = 0, pb = 0, in_cyc = 0, out_delay = 0, sent = 0;
  int dok_last_cyc = -100, last_dok_cyc = -100;
  bit gap_ph = 0;
  logic [7:0] out_q[$];

  always @(negedge clk) begin
    in_t e;
    logic [127:0] ct;
    if (!rst_) begin
      kb = 0; pb = 0; in_cyc = 0; out_q.delete();
    end else begin
      if (eng_cmd == 2'b11) chk("eng_cmd_legal", eng_cmd, 2'b00);
      if (eng_ready && eng_cmd == 2'b01) begin rx_key = {rx_key[119:0], eng_din}; kb++; end
      if (eng_ready && eng_cmd == 2'b10) begin
        rx_pt = {rx_pt[119:0], eng_din}; pb++;
        if (pb == 16) begin
          chk("key_byte_count", kb, 16);
          chk("input_cycles", in_cyc, toggle_mode ? 64 : 32);
          if (exp_in_q.size() == 0) chk("in_queue", exp_in_q.size(), 1);
          else begin
            e = exp_in_q.pop_front();
            chk("eng_key_bytes", rx_key, e.key);
            chk("eng_pt_bytes", rx_pt, e.pt);
          end
          ct = aes_lut(rx_key, rx_pt);
          for (int i = 0; i < (stall5 ? 5 : 16); i++) out_q.push_back(ct[127 - 8*i -: 8]);
          out_delay = 3; sent = 0; gap_ph = 0; kb = 0; pb = 0; in_cyc = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (eng_cmd != 2'b00) in_cyc++;
    eng_ready   = toggle_mode ? (in_cyc % 2 == 0) : 1'b1;
    eng_data_ok = 1'b0;
    eng_dout    = '0;
    if (out_q.size() > 0) begin
      if (out_delay > 0) out_delay--;
      else begin
        if (!(gap_mode && gap_ph)) begin
          eng_data_ok = 1'b1;
          eng_dout = out_q.pop_front();
          sent++;
          last_dok_cyc = cyc;
          if (sent == 16) dok_last_cyc = cyc;
        end
        gap_ph = ~gap_ph;
      end
    end
  end

  // Response sink with programmable hold-off.
  int rdy_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (rsp0_valid || rsp1_valid) rdy_cnt++; else rdy_cnt = 0;
    rsp0_ready = rsp0_valid && (rdy_cnt > rsp_hold);
    rsp1_ready = rsp1_valid && (rdy_cnt > rsp_hold);
  end

  // Request monitor: arbitration order and scoreboard push.
  bit gid_pend = 0;
  logic gid_exp, w, eg;
  always @(negedge clk) begin
    if (!rst_) gid_pend = 0;
    else begin
      if (gid_pend) begin
        chk("grant_id", grant_id, gid_exp);
        chk("busy_after_accept", busy, 1'b1);
        gid_pend = 0;
      end
      if (req0_ready && req1_ready) chk("ready_onehot", {req0_ready, req1_ready}, 2'b01);
      if (req0_ready || req1_ready) begin
        w = req1_ready;
        chk("ready_needs_valid", w ? req1_valid : req0_valid, 1'b1);
        if (exp_grant_q.size() == 0) chk("grant_queue", exp_grant_q.size(), 1);
        else begin
          eg = exp_grant_q.pop_front();
          chk("grant_order", w, eg);
        end
        exp_in_q.push_back('{key: w ? req1_key : req0_key, pt: w ? req1_plain : req0_plain});
        if (w ? want1 : want0) exp_rsp_q.push_back('{ch: w, ct: w ? exp_ct1 : exp_ct0});
        gid_pend = 1; gid_exp = w;
      end
    end
  end

  // Response monitor.
  bit in_resp = 0;
  logic [127:0] held;
  rsp_t r;
  always @(negedge clk) begin
    if (!rst_) in_resp = 0;
    else if (rsp0_valid || rsp1_valid) begin
      if (rsp0_valid && rsp1_valid) chk("rsp_onehot", {rsp0_valid, rsp1_valid}, 2'b01);
      if (!in_resp) begin
        in_resp = 1; held = rsp_cipher;
        chk("rsp_latency", cyc, dok_last_cyc + 1);
      end else begin
        chk("rsp_stable", rsp_cipher, held);
        chk("busy_in_resp", busy, 1'b1);
      end
      if (rsp1_valid ? rsp1_ready : rsp0_ready) begin
        if (exp_rsp_q.size() == 0) chk("rsp_queue", exp_rsp_q.size(), 1);
        else begin
          r = exp_rsp_q.pop_front();
          chk("rsp_channel", rsp1_valid, r.ch);
          chk("rsp_cipher", rsp_cipher, r.ct);
          chk("rsp_grant_id", grant_id, r.ch);
        end
        in_resp = 0;
      end
    end else if (in_resp) begin
      chk("rsp_valid_dropped", rsp0_valid | rsp1_valid, 1'b1);
      in_resp = 0;
    end
  end

  // Timeout monitor.
  int tmo_pulses = 0;
  bit tmo_after = 0;
  always @(negedge clk) begin
    if (rst_ && timeout_err) begin
      tmo_pulses++;
      chk("tmo_interval", cyc - last_dok_cyc, 16);
      tmo_after = 1;
    end else if (tmo_after) begin
      chk("busy_after_tmo", busy, 1'b0);
      chk("no_rsp_after_tmo", {rsp0_valid, rsp1_valid}, 2'b00);
      tmo_after = 0;
    end
  end

  task automatic req(input bit ch, input logic [127:0] k, input logic [127:0] p,
                     input logic [127:0] c, input bit want);
    bit got = 0;
    @(posedge clk); #2;
    if (ch) begin req1_key = k; req1_plain = p; exp_ct1 = c; want1 = want; req1_valid = 1'b1; end
    else    begin req0_key = k; req0_plain = p; exp_ct0 = c; want0 = want; req0_valid = 1'b1; end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ch ? req1_ready : req0_ready) begin got = 1; break; end
    end
    if (!got) chk("req_accept_wait", got, 1'b1);
    @(posedge clk); #2;
    if (ch) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin got = 1; break; end
    end
    if (!got) chk("idle_wait", busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 rst_ = 1'b0;
    @(posedge clk); #2 rst_ = 1'b1;
  endtask

  bit hit;
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, eng_cmd, eng_din,
                          grant_id, busy, timeout_err}, '0);
    chk("reset_cipher", rsp_cipher, '0);
    @(posedge clk); #2 rst_ = 1'b1;

    // FIPS-197 C.1 on channel 0.
    exp_grant_q.push_back(1'b0);
    req(1'b0, V1K, V1P, V1C, 1'b1);
    wait_idle();

    // Tie immediately after reset: channel 0 first, then channel 1.
    pulse_reset();
    exp_grant_q.push_back(1'b0); exp_grant_q.push_back(1'b1);
    fork
      req(1'b0, V1K, V1P, V1C, 1'b1);
      req(1'b1, V2K, V2P, V2C, 1'b1);
    join
    wait_idle();

    // Fairness: both keep requesting, service alternates.
    foreach (exp_grant_q[i]) ;
    exp_grant_q.push_back(1'b0); exp_grant_q.push_back(1'b1);
    exp_grant_q.push_back(1'b0); exp_grant_q.push_back(1'b1);
    fork
      begin req(1'b0, V1K, V1P, V1C, 1'b1); req(1'b0, V2K, V2P, V2C, 1'b1); end
      begin req(1'b1, V2K, V2P, V2C, 1'b1); req(1'b1, V1K, V1P, V1C, 1'b1); end
    join
    wait_idle();

    // Engine backpressure every other cycle plus gaps in data_ok.
    toggle_mode = 1; gap_mode = 1;
    exp_grant_q.push_back(1'b1);
    req(1'b1, V2K, V2P, V2C, 1'b1);
    wait_idle();
    toggle_mode = 0; gap_mode = 0;

    // Response backpressure for 10 cycles.
    rsp_hold = 10;
    exp_grant_q.push_back(1'b0);
    req(1'b0, V2K, V2P, V2C, 1'b1);
    wait_idle();
    rsp_hold = 0;

    // Timeout after 5 bytes, then a normal channel-1 job.
    stall5 = 1;
    exp_grant_q.push_back(1'b0);
    req(1'b0, V1K, V1P, V1C, 1'b0);
    wait_idle();
    stall5 = 0;
    chk("tmo_pulse_count", tmo_pulses, 1);
    exp_grant_q.push_back(1'b1);
    req(1'b1, V1K, V1P, V1C, 1'b1);
    wait_idle();

    // Reset while plaintext byte 7 is on the bus.
    exp_grant_q.push_back(1'b0);
    req(1'b0, V2K, V2P, V2C, 1'b0);
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (eng_cmd == 2'b10 && pb == 7) begin hit = 1; break; end
    end
    chk("reached_pt_byte7", hit, 1'b1);
    #1 rst_ = 1'b0;
    #1;
    chk("midjob_reset_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, eng_cmd, eng_din,
                                 grant_id, busy, timeout_err}, '0);
    chk("midjob_reset_cipher", rsp_cipher, '0);
    exp_in_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_ = 1'b1;
    exp_grant_q.push_back(1'b1);
    req(1'b1, V2K, V2P, V2C, 1'b1);
    wait_idle();

    chk("tmo_pulse_total", tmo_pulses, 1);
    chk("rsp_queue_drained", exp_rsp_q.size(), 0);
    chk("grant_queue_drained", exp_grant_q.size(), 0);
    chk("in_queue_drained", exp_in_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
